rotl_seq_16bit: RTL and testbench

Multi-cycle 16-bit rotate-left unit: the inverse of the combinational 16-bit rotate-right barrel shifter used elsewhere in the design. It accepts an operand and a 4-bit amount on a start pulse and rotates one bit position per clock through a controller/datapath pair. It reports completion with a one-cycle done pulse. It restores data rotated right by s, and serves as the reference-cheap path where a full barrel shifter is not warranted.

---
 rtl/rotl_seq_16bit.sv | 56 +++++
 tb/tb_rotl_seq_16bit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rotl_seq_16bit.sv
// Multi-cycle 16-bit rotate-left: one bit position per clock, result published on a one-cycle done pulse.
// Latency s+2 cycles from accepted start; start is ignored while busy, with no queuing.
module rotl_seq_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [3:0]  s,
  output logic [15:0] w,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  state;
  logic [15:0] r;
  logic [3:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      r     <= 16'h0000;
      cnt   <= 4'd0;
      w     <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            r     <= A;
            cnt   <= s;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // The terminal edge publishes r, so w never shows a partial rotation.
          if (cnt == 4'd0) begin
            w     <= r;
            state <= ST_DONE;
          end else begin
            r   <= {r[14:0], r[15]};
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_SHIFT) || (state == ST_DONE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_rotl_seq_16bit.sv
// Directed and random checks of rotl_seq_16bit against a bit-index rotation model.
module tb_rotl_seq_16bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [3:0]  s;
  logic [15:0] w;
  logic        busy;
  logic        done;

  int tests;
  int fails;

  rotl_seq_16bit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .s     (s),
    .w     (w),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: w[i] = a[(i - sh) mod 16]
  function automatic logic [15:0] model_rotl(input logic [15:0] a, input int sh);
    logic [15:0] res;
    for (int i = 0; i < 16; i++) res[i] = a[(i - sh + 16) % 16];
    return res;
  endfunction

  function automatic logic [15:0] model_rotr(input logic [15:0] a, input int sh);
    logic [15:0] res;
    for (int i = 0; i < 16; i++) res[i] = a[(i + sh) % 16];
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and follow it through done; optionally keep start
  // asserted with junk operands for the whole operation to prove it is ignored.
  task automatic run_op(input logic [15:0] a_in, input logic [3:0] s_in,
                        input logic [15:0] exp_w, input bit junk_start);
    logic [15:0] w_before;
    int          n;
    bit          seen;
    w_before = w;
    A     = a_in;
    s     = s_in;
    start = 1'b1;
    n     = 0;
    seen  = 1'b0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (junk_start) begin
        A = 16'hFFFF;
        s = 4'd3;
      end else begin
        start = 1'b0;
        A     = 16'h0000;
        s     = 4'd0;
      end
      if (done) seen = 1'b1;
      else begin
        check("busy_in_shift", {31'd0, busy}, 32'd1);
        check("w_held_in_shift", {16'd0, w}, {16'd0, w_before});
      end
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("latency", n, s_in + 2);
    check("result_w", {16'd0, w}, {16'd0, exp_w});
    check("busy_in_done", {31'd0, busy}, 32'd1);
    step();
    start = 1'b0;
    check("busy_after", {31'd0, busy}, 32'd0);
    check("done_after", {31'd0, done}, 32'd0);
    check("w_hold_after", {16'd0, w}, {16'd0, exp_w});
  endtask

  initial begin
    logic [15:0] ra;
    logic [3:0]  rs;
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    start = 1'b0;
    A     = 16'h0000;
    s     = 4'd0;
    step();
    step();
    rst = 1'b0;
    check("reset_w", {16'd0, w}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_no_done", {31'd0, done}, 32'd0);
      check("idle_not_busy", {31'd0, busy}, 32'd0);
    end

    run_op(16'h0001, 4'd4, 16'h0010, 1'b0);
    run_op(16'h8001, 4'd1, 16'h0003, 1'b0);
    run_op(16'h0001, 4'd15, 16'h8000, 1'b0);
    run_op(16'hBEEF, 4'd0, 16'hBEEF, 1'b0);

    run_op(16'h1234, 4'd8, 16'h3412, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("no_second_op_done", {31'd0, done}, 32'd0);
      check("no_second_op_busy", {31'd0, busy}, 32'd0);
      check("no_second_op_w", {16'd0, w}, 32'h3412);
    end

    // Reset mid-operation: start in cycle k, rst in cycle k+4.
    A     = 16'h00F0;
    s     = 4'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_w", {16'd0, w}, 32'h0);
    for (int i = 0; i < 14; i++) begin
      step();
      check("abandoned_no_done", {31'd0, done}, 32'd0);
    end
    run_op(16'h00F0, 4'd4, 16'h0F00, 1'b0);

    for (int k = 0; k < 16; k++) begin
      run_op(model_rotr(16'hA5C3, k), k[3:0], 16'hA5C3, 1'b0);
    end

    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom);
      rs = 4'($urandom_range(15, 0));
      run_op(ra, rs, model_rotl(ra, int'(rs)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
